// File: rtl/num_check.sv
// num_check: AXI-Stream sink that checks num_gen traffic arriving from the mesh.
//
// It regenerates the num_gen LFSR sequence and compares every accepted beat
// against it. It also checks TLAST placement and TDEST. The block exposes
// packet, beat and error counters for self-test.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse: clear counters/flags, reload seed, arm
//   stall_en            throttle TREADY to every other cycle
//   axis_s_*            AXI-Stream slave (tvalid, tready, tdata, tlast, tdest)
//   busy / done         armed (RECV) / NUM_PKTS packets received
//   pkt_count           completed packets
//   beat_count          accepted beats (wraps)
//   err_count           data mismatches (saturating)
//   data_err            sticky data-mismatch flag
//   frame_err           sticky TLAST-misplacement flag
//   dest_err            sticky TDEST-mismatch flag
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | not armed, TREADY low
// RECV  | armed, accepting and checking beats
// DONE  | NUM_PKTS packets seen, counters frozen until START
module num_check #(
    parameter int unsigned         TDATAW       = 32,
    parameter int unsigned         TDESTW       = 4,
    parameter int unsigned         LFSR_DW      = 16,
    parameter logic [LFSR_DW-1:0]  LFSR_DEFAULT = 16'hACE1,
    parameter int unsigned         PKT_LEN      = 4,
    parameter int unsigned         NUM_PKTS     = 0,
    parameter logic [TDESTW-1:0]   MY_DEST      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall_en,
    input  logic              axis_s_tvalid,
    output logic              axis_s_tready,
    input  logic [TDATAW-1:0] axis_s_tdata,
    input  logic              axis_s_tlast,
    input  logic [TDESTW-1:0] axis_s_tdest,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count,
    output logic [15:0]       beat_count,
    output logic [15:0]       err_count,
    output logic              data_err,
    output logic              frame_err,
    output logic              dest_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  LAST_IDX   = 8'(PKT_LEN - 1);
    localparam logic [15:0] NUM_PKTS_W = 16'(NUM_PKTS);

    // Taps generalise the 16-bit polynomial (15,14,12,3) to MSB-relative
    // positions plus bit 3, so the default width matches num_gen exactly.
    function automatic logic [LFSR_DW-1:0] lfsr_next(input logic [LFSR_DW-1:0] q);
        return {q[LFSR_DW-2:0], q[LFSR_DW-1] ^ q[LFSR_DW-2] ^ q[LFSR_DW-4] ^ q[3]};
    endfunction

    state_t             state_q, state_d;
    logic [LFSR_DW-1:0] lfsr_q;
    logic [7:0]         beat_idx_q;
    logic               tog_q;
    logic [TDATAW-1:0]  exp_data;
    logic               accept;
    logic               mismatch;
    logic [15:0]        pkt_next;

    // TREADY depends only on registered state and the static throttle select.
    assign axis_s_tready = (state_q == S_RECV) && (!stall_en || tog_q);

    // A beat coinciding with START is dropped from checking and counting.
    assign accept   = axis_s_tvalid && axis_s_tready && !start;
    assign pkt_next = pkt_count + 16'd1;

    always_comb begin
        exp_data                = '0;
        exp_data[LFSR_DW-1:0]   = lfsr_q;
    end

    assign mismatch = (axis_s_tdata != exp_data);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RECV;
            end
            S_RECV: begin
                if (start) begin
                    state_d = S_RECV;
                end else if (accept && axis_s_tlast && (NUM_PKTS != 0) &&
                             (pkt_next == NUM_PKTS_W)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) state_d = S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign busy = (state_q == S_RECV);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= LFSR_DEFAULT;
            beat_idx_q <= '0;
            tog_q      <= 1'b0;
            pkt_count  <= '0;
            beat_count <= '0;
            err_count  <= '0;
            data_err   <= 1'b0;
            frame_err  <= 1'b0;
            dest_err   <= 1'b0;
        end else begin
            // Toggle restarts high on every (re)entry into RECV.
            tog_q <= (state_q != S_RECV || start) ? 1'b1 : ~tog_q;

            if (start) begin
                lfsr_q     <= LFSR_DEFAULT;
                beat_idx_q <= '0;
                pkt_count  <= '0;
                beat_count <= '0;
                err_count  <= '0;
                data_err   <= 1'b0;
                frame_err  <= 1'b0;
                dest_err   <= 1'b0;
            end else if (accept) begin
                beat_count <= beat_count + 16'd1;

                // Resync to the received word so the stream can recover.
                if (mismatch) begin
                    lfsr_q   <= lfsr_next(axis_s_tdata[LFSR_DW-1:0]);
                    data_err <= 1'b1;
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                end else begin
                    lfsr_q <= lfsr_next(lfsr_q);
                end

                if (axis_s_tdest != MY_DEST) dest_err <= 1'b1;

                if (axis_s_tlast) begin
                    if (beat_idx_q != LAST_IDX) frame_err <= 1'b1;
                    beat_idx_q <= '0;
                    pkt_count  <= pkt_next;
                end else begin
                    if (beat_idx_q == LAST_IDX) frame_err <= 1'b1;
                    beat_idx_q <= beat_idx_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_num_check.sv
module tb_num_check;

    localparam int PKT_LEN  = 4;
    localparam int NUM_PKTS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall_en;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tdest;
    logic        busy, done;
    logic [15:0] pkt_count, beat_count, err_count;
    logic        data_err, frame_err, dest_err;

    always #5 clk = ~clk;

    num_check #(
        .TDATAW(32), .TDESTW(4), .LFSR_DW(16), .LFSR_DEFAULT(16'hACE1),
        .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS), .MY_DEST(4'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall_en(stall_en),
        .axis_s_tvalid(tvalid), .axis_s_tready(tready), .axis_s_tdata(tdata),
        .axis_s_tlast(tlast), .axis_s_tdest(tdest),
        .busy(busy), .done(done),
        .pkt_count(pkt_count), .beat_count(beat_count), .err_count(err_count),
        .data_err(data_err), .frame_err(frame_err), .dest_err(dest_err)
    );

    typedef struct {
        int pkts;
        int beats;
        int errs;
        bit d_err;
        bit f_err;
        bit t_err;
        bit dn;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: counters as plain integers, the expected word
    // sequence as a 16-bit value stepped by the polynomial.
    logic [15:0] m_lfsr;
    int          m_idx, m_pkt, m_beat, m_err;
    bit          m_derr, m_ferr, m_terr, m_done;

    // Independent traffic source imitating num_gen.
    logic [15:0] g_lfsr;

    function automatic logic [15:0] ref_next(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[14] ^ v[12] ^ v[3];
        return 16'((32'(v) * 2) % 65536) | 16'(fb);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        g_lfsr = 16'hACE1;
        m_idx = 0; m_pkt = 0; m_beat = 0; m_err = 0;
        m_derr = 0; m_ferr = 0; m_terr = 0; m_done = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input bit last, input logic [3:0] dst);
        exp_t e;
        m_beat = (m_beat + 1) % 65536;
        if (d != {16'h0, m_lfsr}) begin
            if (m_err < 65535) m_err++;
            m_derr = 1;
            m_lfsr = ref_next(d[15:0]);
        end else begin
            m_lfsr = ref_next(m_lfsr);
        end
        if (dst != 4'd0) m_terr = 1;
        if (last) begin
            if (m_idx != PKT_LEN - 1) m_ferr = 1;
            m_idx = 0;
            m_pkt++;
            if (m_pkt == NUM_PKTS) m_done = 1;
        end else begin
            if (m_idx == PKT_LEN - 1) m_ferr = 1;
            m_idx++;
        end
        e.pkts = m_pkt; e.beats = m_beat; e.errs = m_err;
        e.d_err = m_derr; e.f_err = m_ferr; e.t_err = m_terr; e.dn = m_done;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = {16'h0, g_lfsr};
        g_lfsr = ref_next(g_lfsr);
        return w;
    endfunction

    // Called and returns at posedge+2; back-to-back calls keep TVALID high.
    task automatic send_beat(input logic [31:0] d, input bit last, input logic [3:0] dst);
        int budget;
        tvalid = 1'b1; tdata = d; tlast = last; tdest = dst;
        budget = 0;
        forever begin
            @(negedge clk);
            if (tready === 1'b1) break;
            budget++;
            if (budget > 20) begin
                chk("accept_timeout", 32'd0, 32'd1);
                tvalid = 1'b0;
                return;
            end
        end
        model_beat(d, last, dst);
        @(posedge clk); #2;
        tvalid = 1'b0; tlast = 1'b0; tdest = 4'd0;
    endtask

    task automatic send_stream(input int n, input int last_pos, input int bad_idx,
                               input logic [31:0] bad_val, input int dest_idx);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = gen_word();
            if (i == bad_idx) d = bad_val;
            send_beat(d, (i == last_pos), (i == dest_idx) ? 4'd1 : 4'd0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        model_reset();
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Scoreboard monitor: every accepted beat pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tvalid === 1'b1 && tready === 1'b1 && start !== 1'b1) begin
                @(posedge clk); #1;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_pkt",   32'(pkt_count),  32'(e.pkts));
                    chk("mon_beat",  32'(beat_count), 32'(e.beats));
                    chk("mon_err",   32'(err_count),  32'(e.errs));
                    chk("mon_derr",  32'(data_err),   32'(e.d_err));
                    chk("mon_ferr",  32'(frame_err),  32'(e.f_err));
                    chk("mon_terr",  32'(dest_err),   32'(e.t_err));
                    chk("mon_done",  32'(done),       32'(e.dn));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, 32'(tready),     32'd0);
        chk({tag, "_busy"},   32'(busy),       32'd0);
        chk({tag, "_done"},   32'(done),       32'd0);
        chk({tag, "_pkt"},    32'(pkt_count),  32'd0);
        chk({tag, "_beat"},   32'(beat_count), 32'd0);
        chk({tag, "_err"},    32'(err_count),  32'd0);
        chk({tag, "_flags"},  {29'd0, data_err, frame_err, dest_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; start = 1'b0; stall_en = 1'b0;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0; tdest = '0;
        model_reset();
        repeat (2) @(posedge clk); #2;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Clean packet of four beats.
        do_start();
        chk("armed_busy", 32'(busy), 32'd1);
        send_stream(4, 3, -1, 32'h0, -1);
        chk("clean_pkt",   32'(pkt_count),  32'd1);
        chk("clean_beats", 32'(beat_count), 32'd4);
        chk("clean_err",   32'(err_count),  32'd0);
        chk("clean_flags", {29'd0, data_err, frame_err, dest_err}, 32'd0);

        // Corrupt beat 2 with zero.
        do_start();
        send_stream(4, 3, 1, 32'h0, -1);
        chk("corrupt_derr", 32'(data_err),  32'd1);
        chk("corrupt_err",  32'(err_count), 32'(m_err));

        // Early TLAST, then a well-formed packet.
        do_start();
        send_stream(3, 2, -1, 32'h0, -1);
        chk("early_last_ferr", 32'(frame_err), 32'd1);
        chk("early_last_pkt",  32'(pkt_count), 32'd1);
        send_stream(4, 3, -1, 32'h0, -1);
        chk("early_last_pkt2", 32'(pkt_count), 32'd2);
        chk("early_last_derr", 32'(data_err),  32'd0);

        // Missing TLAST at the last index.
        do_start();
        send_stream(4, -1, -1, 32'h0, -1);
        chk("no_last_ferr", 32'(frame_err), 32'd1);
        chk("no_last_pkt",  32'(pkt_count), 32'd0);
        send_stream(1, 0, -1, 32'h0, -1);
        chk("no_last_pkt1", 32'(pkt_count), 32'd1);

        // Wrong TDEST on one beat.
        do_start();
        send_stream(4, 3, -1, 32'h0, 2);
        chk("dest_terr", 32'(dest_err), 32'd1);
        chk("dest_derr", 32'(data_err), 32'd0);

        // Throttled TREADY with continuous TVALID.
        stall_en = 1'b1;
        do_start();
        fork
            send_stream(4, 3, -1, 32'h0, -1);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("stall_tready", 32'(tready), (i % 2 == 0) ? 32'd1 : 32'd0);
            end
        join
        chk("stall_beats", 32'(beat_count), 32'd4);
        chk("stall_err",   32'(err_count),  32'd0);
        stall_en = 1'b0;

        // Randomised traffic against the model.
        for (int it = 0; it < 10; it++) begin
            stall_en = 1'($urandom_range(0, 1));
            do_start();
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < PKT_LEN; b++) begin
                    d = gen_word();
                    if ($urandom_range(0, 7) == 0) d = $urandom;
                    send_beat(d, (b == PKT_LEN - 1),
                              ($urandom_range(0, 15) == 0) ? 4'd1 : 4'd0);
                end
            end
            chk("rand_err",  32'(err_count), 32'(m_err));
            chk("rand_done", 32'(done),      32'(m_done));
        end
        stall_en = 1'b0;

        // Packet limit, third packet refused, re-arm, reset mid-packet.
        do_start();
        send_stream(8, -1, -1, 32'h0, -1);
        chk("limit_done",   32'(done),      32'd0);
        chk("limit_ferr",   32'(frame_err), 32'd1);
        do_start();
        for (int p = 0; p < 2; p++) send_stream(4, 3, -1, 32'h0, -1);
        chk("limit_done2",  32'(done),      32'd1);
        chk("limit_busy",   32'(busy),      32'd0);
        chk("limit_pkt",    32'(pkt_count), 32'd2);
        tvalid = 1'b1; tdata = gen_word(); tlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("limit_tready", 32'(tready), 32'd0);
        end
        @(posedge clk); #2;
        tvalid = 1'b0;
        chk("limit_beats_hold", 32'(beat_count), 32'd8);

        do_start();
        chk("rearm_pkt",  32'(pkt_count),  32'd0);
        chk("rearm_beat", 32'(beat_count), 32'd0);
        chk("rearm_done", 32'(done),       32'd0);
        chk("rearm_busy", 32'(busy),       32'd1);
        send_stream(2, -1, 1, 32'h1234, -1);
        chk("pre_rst_derr", 32'(data_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
